// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath width and the writeback request record
// carried by the multi-cycle result buffer.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Saturating 16-bit increment used by event counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline writeback, multi-cycle result offer and
// register file write port. master = producers/register file side, slave = arbiter.
interface wb_port_arbiter_if;
    import riscv_pkg::*;

    logic            pipe_valid;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_stall;
    logic            mc_valid;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    logic            mc_ready;
    logic            rf_write_en;
    logic [4:0]      rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;

    modport master (
        output pipe_valid, pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  pipe_stall, mc_ready, rf_write_en, rf_rd_addr, rf_rd_data
    );

    modport slave (
        input  pipe_valid, pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output pipe_stall, mc_ready, rf_write_en, rf_rd_addr, rf_rd_data
    );
endinterface

// File: rtl/wb_result_fifo.sv
// FIFO of pending multi-cycle writeback results; DEPTH must be a power of two
// so the pointers wrap naturally.
module wb_result_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t       mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Entry storage; stale contents are harmless because count gates reads
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy, with simultaneous push/pop leaving count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (!do_push_s && do_pop_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and
// buffered mul/div results. Define WB_ARB_STATS_EN to add stat_forced/stat_full.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]        stat_forced,
    output logic [15:0]        stat_full
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t         head_s;
    wb_req_t         push_data_s;
    logic            full_s;
    logic            empty_s;
    logic            pipe_req_s;
    logic            forced_s;
    logic            head_grant_s;
    logic            mc_ready_s;
    logic            rf_we_s;
    logic [4:0]      rf_addr_s;
    logic [XLEN-1:0] rf_data_s;
    logic [SW-1:0]   starve_cnt_r;

    assign push_data_s  = '{rd: bus.mc_rd, data: bus.mc_data};
    assign pipe_req_s   = bus.pipe_valid & bus.pipe_we & (bus.pipe_rd != 5'd0);
    assign forced_s     = pipe_req_s & ~empty_s & (starve_cnt_r == SW'(STARVE_LIMIT));
    assign head_grant_s = rst_n & ~empty_s & (~pipe_req_s | forced_s);
    // Ready is held low throughout reset, not only after the first edge
    assign mc_ready_s   = rst_n & ~full_s;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.mc_valid & mc_ready_s),
        .push_data (push_data_s),
        .pop       (head_grant_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s)
    );

    // Write-port mux; a granted head with rd=0 is consumed silently
    always_comb begin
        rf_we_s   = 1'b0;
        rf_addr_s = 5'd0;
        rf_data_s = {XLEN{1'b0}};
        if (!rst_n) begin
            rf_we_s = 1'b0;
        end else if (head_grant_s) begin
            if (head_s.rd != 5'd0) begin
                rf_we_s   = 1'b1;
                rf_addr_s = head_s.rd;
                rf_data_s = head_s.data;
            end else begin
                rf_we_s = 1'b0;
            end
        end else if (pipe_req_s) begin
            rf_we_s   = 1'b1;
            rf_addr_s = bus.pipe_rd;
            rf_data_s = bus.pipe_data;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    assign bus.rf_write_en = rf_we_s;
    assign bus.rf_rd_addr  = rf_addr_s;
    assign bus.rf_rd_data  = rf_data_s;
    assign bus.mc_ready    = mc_ready_s;
    assign bus.pipe_stall  = rst_n & forced_s;

    // Starvation counter: counts denied cycles of a waiting head, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (empty_s || head_grant_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (starve_cnt_r != SW'(STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_forced_r;
    logic [15:0] stat_full_r;

    // Saturating event counters for forced grants and back-pressured offers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_forced_r <= 16'd0;
            stat_full_r   <= 16'd0;
        end else begin
            if (forced_s) begin
                stat_forced_r <= sat_inc16(stat_forced_r);
            end
            if (bus.mc_valid && !mc_ready_s) begin
                stat_full_r <= sat_inc16(stat_full_r);
            end
        end
    end

    assign stat_forced = stat_forced_r;
    assign stat_full   = stat_full_r;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: stimulus queues expected
// register-file writes, a negedge monitor pops and compares each observed write.
module tb_wb_port_arbiter;
    import riscv_pkg::*;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic  clk;
    logic  rst_n;
    int    cyc;
    int    errors;
    int    checks;
    exp_t  exp_q[$];

    wb_port_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_forced;
    logic [15:0] stat_full;
`endif

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_forced (stat_forced),
        .stat_full   (stat_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next queued write, in the same cycle
    always @(negedge clk) begin
        exp_t e;
        if (bus.rf_write_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.rf_write_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", 32'(bus.rf_rd_addr), 32'(e.rd));
                chk("wr_data", bus.rf_rd_data, e.data);
            end
        end
    end

    task automatic step(input logic rst, input logic pv, input logic pwe,
                        input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                        input logic estall, input logic eready, input string nm);
        exp_t e;
        rst_n          = rst;
        bus.pipe_valid = pv;
        bus.pipe_we    = pwe;
        bus.pipe_rd    = prd;
        bus.pipe_data  = pd;
        bus.mc_valid   = mv;
        bus.mc_rd      = mrd;
        bus.mc_data    = md;
        if (ewe) begin
            e.cyc  = cyc;
            e.rd   = erd;
            e.data = ed;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk({nm, "_stall"}, 32'(bus.pipe_stall), 32'(estall));
        chk({nm, "_ready"}, 32'(bus.mc_ready), 32'(eready));
        if (!ewe) begin
            chk({nm, "_idle_addr"}, 32'(bus.rf_rd_addr), 32'd0);
            chk({nm, "_idle_data"}, bus.rf_rd_data, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc    = 0;
        errors = 0;
        checks = 0;
        //    rst pv we rd     pdata         mv rd     mdata         ewe rd     edata         st rdy
        step(0, 1, 1, 5'd5,  32'h1234, 1, 5'd7,  32'hBEEF, 0, 5'd0,  32'h0,    0, 0, "reset");
        // pipe-only, zero latency
        step(1, 1, 1, 5'd5,  32'h1234, 0, 5'd0,  32'h0,    1, 5'd5,  32'h1234, 0, 1, "pipe_only");
        // mc-only: written the cycle after the push, then empty
        step(1, 0, 0, 5'd0,  32'h0,    1, 5'd7,  32'hBEEF, 0, 5'd0,  32'h0,    0, 1, "mc_push");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd7,  32'hBEEF, 0, 1, "mc_write");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "mc_empty");
        // starvation: 4 pipe writes, forced head, pipe resumes
        step(1, 0, 0, 5'd0,  32'h0,    1, 5'd9,  32'h9999, 0, 5'd0,  32'h0,    0, 1, "st_push");
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'h0,
                 1, 5'(i), 32'h100 + 32'(i), 0, 1, "st_pipe");
        end
        step(1, 1, 1, 5'd10, 32'hAAAA, 0, 5'd0,  32'h0,    1, 5'd9,  32'h9999, 1, 1, "st_forced");
        step(1, 1, 1, 5'd10, 32'hAAAA, 0, 5'd0,  32'h0,    1, 5'd10, 32'hAAAA, 0, 1, "st_resume");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "st_idle");
        // full: two pushes under a busy pipe, third offer held
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd11, 32'hB1,   1, 5'd3,  32'h3,    0, 1, "full_a");
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd12, 32'hB2,   1, 5'd3,  32'h3,    0, 1, "full_b");
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd13, 32'hB3,   1, 5'd3,  32'h3,    0, 0, "full_c");
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd13, 32'hB3,   1, 5'd3,  32'h3,    0, 0, "full_d");
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd13, 32'hB3,   1, 5'd3,  32'h3,    0, 0, "full_e");
        step(1, 1, 1, 5'd3,  32'h3,    1, 5'd13, 32'hB3,   1, 5'd11, 32'hB1,   1, 0, "full_f");
        step(1, 0, 0, 5'd0,  32'h0,    1, 5'd13, 32'hB3,   1, 5'd12, 32'hB2,   0, 1, "full_g");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd13, 32'hB3,   0, 1, "full_h");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "full_i");
`ifdef WB_ARB_STATS_EN
        chk("stat_full", 32'(stat_full), 32'd4);
        chk("stat_forced", 32'(stat_forced), 32'd2);
`endif
        // rd=0: buffered x0 result pops without a strobe, pipe rd=0 is no request
        step(1, 0, 0, 5'd0,  32'h0,    1, 5'd0,  32'h5555, 0, 5'd0,  32'h0,    0, 1, "x0_push");
        step(1, 1, 1, 5'd0,  32'h77,   0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "x0_pop");
        step(1, 0, 0, 5'd0,  32'h0,    1, 5'd14, 32'hE,    0, 5'd0,  32'h0,    0, 1, "x0_next");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd14, 32'hE,    0, 1, "x0_wr");
        // reset mid-flight discards two buffered entries
        step(1, 1, 1, 5'd3,  32'h6,    1, 5'd20, 32'hC1,   1, 5'd3,  32'h6,    0, 1, "rst_a");
        step(1, 1, 1, 5'd3,  32'h7,    1, 5'd21, 32'hC2,   1, 5'd3,  32'h7,    0, 1, "rst_b");
        step(0, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 0, "rst_hold");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "rst_rel");
        step(1, 0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, "rst_after");
        @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
